// File: rtl/neuroset_pkg.sv
// Shared types for the neuroset host loader.
// States, error codes and the "no result" marker.
package neuroset_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GOP,
    S_WLOW,
    S_WHIGH,
    S_RESP
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_LONG    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [3:0] RESULT_NONE = 4'b1111;

  function automatic logic in_wait(
    input state_e s
  );
    return (s == S_WLOW) || (s == S_WHIGH);
  endfunction

endpackage

// File: rtl/neuroset_watchdog.sv
// Wait-state cycle counter for the host loader.
// Present only when NEUROSET_TIMEOUT_EN is defined.
`ifdef NEUROSET_TIMEOUT_EN
module neuroset_watchdog #(
  parameter int LIMIT = 2**20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Fires on the LIMIT-th enabled cycle after a clear.
  assign expired_o = enable_i &&
                     (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/neuroset_host_loader.sv
// Host initiator: streams one image into the CNN database, pulses GO,
// returns the class. NEUROSET_TIMEOUT_EN adds a STOP watchdog.
module neuroset_host_loader
  import neuroset_pkg::*;
#(
  parameter int SIZE_1      = 11,
  parameter int ADDR_W      = 13,
  parameter int NUM_WORDS   = 784,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SIZE_1-1:0] s_data,
  input  logic              s_last,
  output logic              we_database,
  output logic [SIZE_1-1:0] dp_database,
  output logic [ADDR_W-1:0] address_p_database,
  output logic              GO,
  input  logic              cnn_stop,
  input  logic [3:0]        cnn_result,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [3:0]        r_data,
  output logic [1:0]        r_err,
  output logic              busy
);

  localparam int CW = $clog2(NUM_WORDS) + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [SIZE_1-1:0] dp_q, dp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              go_q, go_d;
  logic [3:0]        rdata_q, rdata_d;
  logic [1:0]        rerr_q, rerr_d;

  logic              s_hs;
  logic              last_word;
  logic [ADDR_W-1:0] wr_addr;
  logic              wd_expired;

  assign s_ready   = (state_q == S_LOAD);
  assign s_hs      = s_valid && s_ready;
  assign last_word = (cnt_q == CW'(NUM_WORDS - 1));
  assign wr_addr   = ADDR_W'(BASE_ADDR) +
                     ADDR_W'(cnt_q);

  assign we_database        = we_q;
  assign dp_database        = dp_q;
  assign address_p_database = addr_q;
  assign GO                 = go_q;
  assign r_valid            = (state_q == S_RESP);
  assign r_data             = rdata_q;
  assign r_err              = rerr_q;
  assign busy               = (state_q != S_IDLE);

`ifdef NEUROSET_TIMEOUT_EN
  neuroset_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == S_GOP),
    .enable_i  (in_wait(state_q)),
    .expired_o (wd_expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    dp_d    = dp_q;
    addr_d  = addr_q;
    go_d    = 1'b0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!r_valid) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          rerr_d  = ERR_OK;
        end
      end
      S_LOAD: begin
        if (s_hs) begin
          we_d   = 1'b1;
          dp_d   = s_data;
          addr_d = wr_addr;
          cnt_d  = cnt_q + CW'(1);
          // A missing s_last on the final word is flagged but still run.
          if (last_word) begin
            state_d = S_GOP;
            if (!s_last) begin
              rerr_d = ERR_LONG;
            end
          end else if (s_last) begin
            state_d = S_RESP;
            rerr_d  = ERR_SHORT;
            rdata_d = RESULT_NONE;
          end
        end
      end
      S_GOP: begin
        go_d    = 1'b1;
        state_d = S_WLOW;
      end
      S_WLOW: begin
        // A STOP still high from the previous image must fall first.
        if (!cnn_stop) begin
          state_d = S_WHIGH;
        end else if (wd_expired) begin
          state_d = S_RESP;
          rerr_d  = ERR_TIMEOUT;
          rdata_d = RESULT_NONE;
        end
      end
      S_WHIGH: begin
        if (cnn_stop) begin
          state_d = S_RESP;
          rdata_d = cnn_result;
        end else if (wd_expired) begin
          state_d = S_RESP;
          rerr_d  = ERR_TIMEOUT;
          rdata_d = RESULT_NONE;
        end
      end
      S_RESP: begin
        if (r_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      dp_q    <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      go_q    <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      dp_q    <= dp_d;
      addr_q  <= addr_d;
      go_q    <= go_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: tb/tb_neuroset_host_loader.sv
// Bench for neuroset_host_loader: directed images, write scoreboard,
// GO/result checks. Define NEUROSET_TIMEOUT_EN to cover the watchdog.
module tb_neuroset_host_loader;

  localparam int SIZE_1 = 11;
  localparam int ADDR_W = 13;
  localparam int NW     = 784;
  localparam int BASE   = 0;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, s_last;
  logic [SIZE_1-1:0] s_data;
  logic              we_database;
  logic [SIZE_1-1:0] dp_database;
  logic [ADDR_W-1:0] address_p_database;
  logic              GO, cnn_stop;
  logic [3:0]        cnn_result;
  logic              r_valid, r_ready;
  logic [3:0]        r_data;
  logic [1:0]        r_err;
  logic              busy;

  neuroset_host_loader #(
    .SIZE_1      (SIZE_1),
    .ADDR_W      (ADDR_W),
    .NUM_WORDS   (NW),
    .BASE_ADDR   (BASE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_data             (s_data),
    .s_last             (s_last),
    .we_database        (we_database),
    .dp_database        (dp_database),
    .address_p_database (address_p_database),
    .GO                 (GO),
    .cnn_stop           (cnn_stop),
    .cnn_result         (cnn_result),
    .r_valid            (r_valid),
    .r_ready            (r_ready),
    .r_data             (r_data),
    .r_err              (r_err),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model state: expected writes and expected result of the image.
  logic [ADDR_W-1:0] wq_a[$];
  logic [SIZE_1-1:0] wq_d[$];
  logic [1:0]        exp_err = 2'd0;
  logic [3:0]        exp_data = 4'd0;
  bit                go_allowed = 1'b0;
  int                wr_cnt = 0;
  int                go_cnt = 0;
  int                last_we_cyc = 0;
  int                last_hs_cyc = 0;
  int                go_cyc = 0;
  int                rv_cyc = 0;
  logic              prev_go = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [SIZE_1-1:0] word(input int i,
                                             input int seed);
    if (seed == 0) return SIZE_1'(i);
    return SIZE_1'(i * 37 + seed * 101);
  endfunction

  task automatic set_exp(input logic [1:0] e, input logic [3:0] d);
    exp_err  = e;
    exp_data = d;
    wr_cnt   = 0;
    go_cnt   = 0;
  endtask

  // Compare process: every write, every GO, every valid result.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] a;
    logic [SIZE_1-1:0] d;
    if (rst_n) begin
      if (we_database) begin
        wr_cnt++;
        last_we_cyc = cyc;
        if (wq_a.size() == 0) begin
          chk("write_unexpected", 1, 0);
        end else begin
          a = wq_a.pop_front();
          d = wq_d.pop_front();
          chk("write_addr", address_p_database, a);
          chk("write_data", dp_database, d);
        end
      end
      if (GO) begin
        go_cnt++;
        go_cyc = cyc;
        chk("go_allowed", go_allowed, 1);
        chk("go_after_write", cyc - last_we_cyc, 1);
        chk("go_pending_writes", wq_a.size(), 0);
        chk("go_one_cycle", prev_go, 0);
        go_allowed = 1'b0;
      end
      if (r_valid) begin
        chk("r_data", r_data, exp_data);
        chk("r_err", r_err, exp_err);
        chk("s_ready_while_rvalid", s_ready, 0);
      end
    end
    prev_go = GO;
  end

  task automatic send_image(input int n, input int last_idx,
                            input int seed, input int abort_at);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) break;
      s_valid = 1'b1;
      s_data  = word(i, seed);
      s_last  = (i == last_idx);
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        chk("s_ready_timeout", 0, 1);
        break;
      end
      wq_a.push_back(ADDR_W'(BASE + i));
      wq_d.push_back(s_data);
      last_hs_cyc = cyc;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_go(input string nm);
    int t = 0;
    @(negedge clk);
    while (!GO && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(nm, GO, 1);
    #1;
  endtask

  task automatic wait_rv(input string nm);
    int t = 0;
    @(negedge clk);
    while (!r_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    rv_cyc = cyc;
    chk(nm, r_valid, 1);
    #1;
  endtask

  task automatic accept();
    @(negedge clk);
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    @(negedge clk);
    chk("rvalid_drop", r_valid, 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_we"}, we_database, 0);
    chk({nm, "_dp"}, dp_database, 0);
    chk({nm, "_addr"}, address_p_database, BASE);
    chk({nm, "_go"}, GO, 0);
    chk({nm, "_r_valid"}, r_valid, 0);
    chk({nm, "_r_data"}, r_data, 0);
    chk({nm, "_r_err"}, r_err, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    cnn_stop   = 1'b0;
    cnn_result = 4'hF;
    r_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: full image 0..783, result 7
    set_exp(2'd0, 4'd7);
    go_allowed = 1'b1;
    send_image(NW, NW - 1, 0, -1);
    wait_go("t1_go");
    chk("t1_go_latency", go_cyc - last_hs_cyc, 2);
    repeat (3) @(negedge clk);
    cnn_result = 4'd7;
    cnn_stop   = 1'b1;
    wait_rv("t1_rvalid");
    chk("t1_r_data", r_data, 4'd7);
    chk("t1_r_err", r_err, 2'd0);
    chk("t1_writes", wr_cnt, 784);
    chk("t1_go_count", go_cnt, 1);
    accept();

    // 2: short frame, s_last on word 10
    set_exp(2'd1, 4'hF);
    go_allowed = 1'b0;
    send_image(11, 10, 2, -1);
    wait_rv("t2_rvalid");
    chk("t2_writes", wr_cnt, 11);
    chk("t2_r_data", r_data, 4'hF);
    chk("t2_r_err", r_err, 2'd1);
    chk("t2_go_count", go_cnt, 0);
    accept();

    // 3: STOP still high from run 1 when GO fires
    cnn_result = 4'hF;
    set_exp(2'd0, 4'd3);
    go_allowed = 1'b1;
    send_image(NW, NW - 1, 3, -1);
    wait_go("t3_go");
    cnn_result = 4'd9;
    repeat (6) begin
      @(negedge clk);
      chk("t3_stale_no_capture", r_valid, 0);
    end
    cnn_stop = 1'b0;
    repeat (2) @(negedge clk);
    cnn_result = 4'd3;
    cnn_stop   = 1'b1;
    wait_rv("t3_rvalid");
    chk("t3_r_data", r_data, 4'd3);

    // 4: result held 50 cycles with next image pending
    s_valid = 1'b1;
    s_data  = word(0, 4);
    s_last  = 1'b0;
    repeat (50) begin
      @(negedge clk);
      chk("t4_s_ready_low", s_ready, 0);
      chk("t4_r_valid_held", r_valid, 1);
      chk("t4_r_data_stable", r_data, 4'd3);
    end
    accept();
    set_exp(2'd1, 4'hF);
    go_allowed = 1'b0;
    send_image(5, 4, 4, -1);
    wait_rv("t4_rvalid");
    chk("t4_writes", wr_cnt, 5);
    chk("t4_r_err", r_err, 2'd1);
    accept();

    // long frame: no s_last on the final word
    set_exp(2'd2, 4'd5);
    go_allowed = 1'b1;
    send_image(NW, -1, 6, -1);
    wait_go("tl_go");
    cnn_stop = 1'b0;
    repeat (2) @(negedge clk);
    cnn_result = 4'd5;
    cnn_stop   = 1'b1;
    wait_rv("tl_rvalid");
    chk("tl_r_err", r_err, 2'd2);
    chk("tl_r_data", r_data, 4'd5);
    chk("tl_writes", wr_cnt, 784);
    accept();

    // 5: reset at word 400
    set_exp(2'd0, 4'd0);
    go_allowed = 1'b0;
    send_image(NW, NW - 1, 8, 400);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5");
    chk("t5_writes_before_reset", wr_cnt, 399);
    wq_a.delete();
    wq_d.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_exp(2'd1, 4'hF);
    send_image(3, 2, 10, -1);
    wait_rv("t5_rvalid");
    chk("t5_writes_after", wr_cnt, 3);
    chk("t5_go_count", go_cnt, 0);
    accept();

    // 6: STOP never rises
    cnn_stop = 1'b0;
`ifdef NEUROSET_TIMEOUT_EN
    set_exp(2'd3, 4'hF);
`else
    set_exp(2'd0, 4'd0);
`endif
    go_allowed = 1'b1;
    send_image(NW, NW - 1, 11, -1);
    wait_go("t6_go");
`ifdef NEUROSET_TIMEOUT_EN
    wait_rv("t6_rvalid");
    chk("t6_timeout_latency", rv_cyc - go_cyc, TMO);
    chk("t6_r_err", r_err, 2'd3);
    chk("t6_r_data", r_data, 4'hF);
    accept();
`else
    repeat (200) begin
      @(negedge clk);
      chk("t6_wait_forever", {busy, r_valid}, 2'b10);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
